code_entry: RTL and testbench
=============================

Name: code_entry

Overview:
- Front-end input stage of the Bulls & Cows datapath; feeds the game FSM with one validated 4-digit secret or guess per handshake.
- Debounces the raw enter push button and collects four BCD digits from a 4-bit switch bank, one digit per press.
- Rejects non-decimal digits and codes with repeated digits.
- Presents the accepted 16-bit code with a valid/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles the synchronized button must hold a new level before it is accepted (5 ms at 50 MHz); must be >= 2.
- CHECK_REPEAT, 1, 1 = reject codes containing duplicate digits; 0 = accept any decimal code.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- digit_sw  input  4  current digit on switches (BCD, valid 0..9).
- enter_button  input  1  raw, asynchronous, bouncing push button; active-high.
- clear  input  1  synchronous clear of the partial or offered code.
- code  output  16  accepted code; the first digit entered is in [15:12] and the last in [3:0].
- code_valid  output  1  code is stable and offered to the consumer.
- code_ready  input  1  consumer accepts code when high together with code_valid.
- digit_count  output  3  digits collected so far, 0..4 (display aid).
- bad_digit  output  1  one-cycle pulse: press rejected because digit_sw > 9.
- dup_error  output  1  level: last 4-digit code rejected for a repeat.

Behaviour:
- Reset (reset low, asynchronous): state=COLLECT; code=0; code_valid=0; digit_count=0; bad_digit=0; dup_error=0; debounce counter=0; stable button level=0.
- Button path:
  - 2-flop synchronizer on enter_button.
  - Counter increments while the synchronized level differs from the stable level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronized value and the counter clears.
  - press = one-cycle pulse on stable 0->1. Release edges generate nothing.
  - Bounce shorter than DEBOUNCE_CYCLES produces no press.
- Latency: if raw enter_button is high from cycle N with no bounce, press is high in cycle N+DEBOUNCE_CYCLES+2. The state/code update is visible at cycle N+DEBOUNCE_CYCLES+3.
- FSM states: COLLECT, CHECK, OFFER.
- COLLECT:
  - On press with digit_sw <= 9: code <= {code[11:0], digit_sw}, digit_count+1, dup_error <= 0.
  - When digit_count becomes 4, go to CHECK.
  - On press with digit_sw > 9: bad_digit pulses for 1 cycle; code and count are unchanged.
- CHECK (exactly 1 cycle):
  - Compare all 6 nibble pairs.
  - If CHECK_REPEAT=1 and any pair is equal: dup_error <= 1, code <= 0, digit_count <= 0, back to COLLECT.
  - Otherwise go to OFFER.
- OFFER:
  - code_valid=1 and code is held constant.
  - When code_valid && code_ready on a rising edge, the transfer completes. Next cycle: code_valid=0, code=0, digit_count=0, state COLLECT.
  - Presses are ignored in OFFER and CHECK; they are neither queued nor flagged.
- code_ready may be high before code_valid; it has no effect outside OFFER. Minimum offer-to-accept is 1 cycle; back-to-back codes need at least 4 new presses.
- clear (any state): next cycle state=COLLECT, code=0, digit_count=0, code_valid=0, dup_error=0.
  - clear takes priority over press and over a simultaneous handshake; that transfer does not happen.
  - clear is the only way code_valid drops without a handshake.
- Simultaneous press and bad digit in the 4th position: rejected; the code stays at 3 digits.
- Reset asserted mid-debounce or mid-offer: everything returns to reset values immediately; any partial code is lost.

Test Plan (DEBOUNCE_CYCLES=4, CHECK_REPEAT=1):
- Clean presses of digits 1,2,3,4, code_ready=1 -> code_valid rises 1 cycle after the 4th count update with code=16'h1234; drops next cycle; digit_count returns to 0.
- Bounce: enter_button toggles every 2 cycles for 20 cycles, then stays high -> exactly one digit accepted; digit_count 0->1 at exactly DEBOUNCE_CYCLES+3 cycles after the final rise.
- Digits 5,7,5,1 -> after the 4th press, CHECK sets dup_error=1, code_valid never rises, digit_count=0; the next valid press clears dup_error.
- Press with digit_sw=4'hC after digits 9,8 -> bad_digit 1-cycle pulse; digit_count stays 2, code=16'h0098.
- Code 16'h0937 entered, code_ready=0 for 10 cycles -> code_valid held and code stable; extra presses ignored. code_ready=1 -> accepted in one cycle.
- clear asserted in OFFER together with code_ready=1 -> no transfer; code_valid=0 and code=0 next cycle. reset pulled low mid-collection -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/code_entry_if.sv
// Code handshake bundle between the entry front-end (master) and the game FSM (slave).
// The master drives the 16-bit code and its valid flag, and the slave answers with ready.
interface code_entry_if;
  logic [15:0] code;
  logic        code_valid;
  logic        code_ready;

  modport master (output code, output code_valid, input code_ready);
  modport slave  (input code, input code_valid, output code_ready);
endinterface

// File: rtl/code_entry.sv
// Bulls & Cows entry stage: debounces the enter button, collects four BCD digits,
// rejects bad or repeated digits, and offers the finished code over a valid/ready handshake.
module code_entry #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit CHECK_REPEAT    = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        digit_sw,
  input  logic              enter_button,
  input  logic              clear,
  code_entry_if.master      out_if,
  output logic [2:0]        digit_count,
  output logic              bad_digit,
  output logic              dup_error
);

  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {COLLECT, CHECK, OFFER} state_t;

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d, stable_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;

  state_t           state_q, state_d;
  logic [15:0]      code_q, code_d;
  logic [2:0]       count_q, count_d;
  logic             bad_q, bad_d;
  logic             dup_q, dup_d;
  logic             has_dup;

  // Debounce: the stable level only moves after the synchronized level has differed
  // from it for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= enter_button;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign press = stable_q & ~stable_prev_q;

  always_comb begin
    has_dup = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (code_q[i*4 +: 4] == code_q[j*4 +: 4]) begin
          has_dup = 1'b1;
        end
      end
    end
  end

  // clear wins over everything, including a handshake landing in the same cycle.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    count_d = count_q;
    dup_d   = dup_q;
    bad_d   = 1'b0;
    if (clear) begin
      state_d = COLLECT;
      code_d  = '0;
      count_d = '0;
      dup_d   = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (press) begin
            if (digit_sw <= 4'd9) begin
              code_d  = {code_q[11:0], digit_sw};
              count_d = count_q + 3'd1;
              dup_d   = 1'b0;
              if (count_q == 3'd3) begin
                state_d = CHECK;
              end
            end else begin
              bad_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (CHECK_REPEAT && has_dup) begin
            dup_d   = 1'b1;
            code_d  = '0;
            count_d = '0;
            state_d = COLLECT;
          end else begin
            state_d = OFFER;
          end
        end
        OFFER: begin
          if (out_if.code_ready) begin
            code_d  = '0;
            count_d = '0;
            state_d = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      code_q  <= '0;
      count_q <= '0;
      bad_q   <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      count_q <= count_d;
      bad_q   <= bad_d;
      dup_q   <= dup_d;
    end
  end

  assign out_if.code       = code_q;
  assign out_if.code_valid = (state_q == OFFER);
  assign digit_count       = count_q;
  assign bad_digit         = bad_q;
  assign dup_error         = dup_q;

endmodule

// File: tb/tb_code_entry.sv
// Self-checking bench for code_entry with DEBOUNCE_CYCLES=4 and duplicate rejection on;
// directed scenarios plus randomized codes checked against a digit-queue model.
module tb_code_entry;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit_sw = 4'd0;
  logic       enter = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] cnt;
  logic       bad_digit, dup_error;

  code_entry_if ifc();

  int total = 0;
  int bad   = 0;
  int mq[$];

  code_entry #(.DEBOUNCE_CYCLES(DB), .CHECK_REPEAT(1'b1)) dut (
    .clock(clk), .reset(rst_n), .digit_sw(digit_sw), .enter_button(enter),
    .clear(clr), .out_if(ifc), .digit_count(cnt), .bad_digit(bad_digit),
    .dup_error(dup_error)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise the button cleanly and return at the negedge where the update is first visible.
  task automatic press_start(input logic [3:0] d);
    digit_sw = d;
    enter    = 1'b1;
    tick(DB + 3);
  endtask

  task automatic press_end();
    enter = 1'b0;
    tick(DB + 4);
  endtask

  function automatic logic [15:0] mcode();
    int c = 0;
    foreach (mq[i]) c = c * 16 + mq[i];
    return 16'(c);
  endfunction

  function automatic bit mhasdup();
    for (int i = 0; i < mq.size(); i++)
      for (int j = i + 1; j < mq.size(); j++)
        if (mq[i] == mq[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    total++; if (cnt !== 3'd0 || ifc.code !== 16'h0 || ifc.code_valid !== 1'b0)
      begin bad++; $display("FAIL reset_outs: cnt=%0d code=%h valid=%b want 0/0000/0", cnt, ifc.code, ifc.code_valid); end
    total++; if (bad_digit !== 1'b0 || dup_error !== 1'b0)
      begin bad++; $display("FAIL reset_flags: bad_digit=%b dup=%b want 0/0", bad_digit, dup_error); end
    @(negedge clk); rst_n = 1'b1; tick(2);
    total++; if (cnt !== 3'd0 || ifc.code_valid !== 1'b0)
      begin bad++; $display("FAIL reset_release: cnt=%0d valid=%b want 0/0", cnt, ifc.code_valid); end
    $display("reset checked");
  endtask

  task automatic test_basic();
    logic [15:0] exp = 16'h0;
    logic [3:0] d;
    ifc.code_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 4'(k + 1);
      press_start(d);
      exp = {exp[11:0], d};
      total++; if (cnt !== 3'(k + 1) || ifc.code !== exp)
        begin bad++; $display("FAIL basic_digit%0d: cnt=%0d code=%h want %0d/%h", k, cnt, ifc.code, k + 1, exp); end
      total++; if (ifc.code_valid !== 1'b0)
        begin bad++; $display("FAIL basic_early_valid%0d: valid=%b want 0", k, ifc.code_valid); end
      if (k < 3) press_end();
    end
    tick(1);
    total++; if (ifc.code_valid !== 1'b1 || ifc.code !== 16'h1234)
      begin bad++; $display("FAIL basic_offer: valid=%b code=%h want 1/1234", ifc.code_valid, ifc.code); end
    tick(1);
    total++; if (ifc.code_valid !== 1'b0 || cnt !== 3'd0 || ifc.code !== 16'h0)
      begin bad++; $display("FAIL basic_accept: valid=%b cnt=%0d code=%h want 0/0/0000", ifc.code_valid, cnt, ifc.code); end
    ifc.code_ready = 1'b0;
    press_end();
    $display("basic code 1234 transferred");
  endtask

  task automatic test_bounce();
    digit_sw = 4'd6;
    for (int i = 0; i < 10; i++) begin
      enter = (i % 2 == 0);
      tick(2);
    end
    total++; if (cnt !== 3'd0)
      begin bad++; $display("FAIL bounce_none: cnt=%0d want 0", cnt); end
    enter = 1'b1;
    tick(DB + 2);
    total++; if (cnt !== 3'd0)
      begin bad++; $display("FAIL bounce_early: cnt=%0d want 0", cnt); end
    tick(1);
    total++; if (cnt !== 3'd1 || ifc.code !== 16'h0006)
      begin bad++; $display("FAIL bounce_accept: cnt=%0d code=%h want 1/0006", cnt, ifc.code); end
    press_end();
    clr = 1'b1; tick(1); clr = 1'b0;
    total++; if (cnt !== 3'd0 || ifc.code !== 16'h0)
      begin bad++; $display("FAIL clear_collect: cnt=%0d code=%h want 0/0000", cnt, ifc.code); end
    $display("bounce produced single digit");
  endtask

  task automatic test_dup();
    int ds[4] = '{5, 7, 5, 1};
    for (int k = 0; k < 4; k++) begin
      press_start(4'(ds[k]));
      if (k < 3) press_end();
    end
    tick(1);
    total++; if (dup_error !== 1'b1 || cnt !== 3'd0 || ifc.code !== 16'h0 || ifc.code_valid !== 1'b0)
      begin bad++; $display("FAIL dup_reject: dup=%b cnt=%0d code=%h valid=%b want 1/0/0000/0", dup_error, cnt, ifc.code, ifc.code_valid); end
    tick(3);
    total++; if (ifc.code_valid !== 1'b0 || dup_error !== 1'b1)
      begin bad++; $display("FAIL dup_hold: valid=%b dup=%b want 0/1", ifc.code_valid, dup_error); end
    press_end();
    press_start(4'd2);
    total++; if (dup_error !== 1'b0 || cnt !== 3'd1)
      begin bad++; $display("FAIL dup_cleared: dup=%b cnt=%0d want 0/1", dup_error, cnt); end
    press_end();
    clr = 1'b1; tick(1); clr = 1'b0;
    $display("code 5751 rejected as duplicate");
  endtask

  task automatic test_bad_digit();
    press_start(4'd9); press_end();
    press_start(4'd8); press_end();
    press_start(4'hC);
    total++; if (bad_digit !== 1'b1)
      begin bad++; $display("FAIL bad_pulse: bad_digit=%b want 1", bad_digit); end
    total++; if (cnt !== 3'd2 || ifc.code !== 16'h0098)
      begin bad++; $display("FAIL bad_keep: cnt=%0d code=%h want 2/0098", cnt, ifc.code); end
    tick(1);
    total++; if (bad_digit !== 1'b0)
      begin bad++; $display("FAIL bad_width: bad_digit=%b want 0", bad_digit); end
    press_end();
    clr = 1'b1; tick(1); clr = 1'b0;
    $display("digit C rejected");
  endtask

  task automatic test_offer_hold();
    int ds[4] = '{0, 9, 3, 7};
    ifc.code_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      press_start(4'(ds[k]));
      if (k < 3) press_end();
    end
    tick(1);
    for (int i = 0; i < 10; i++) begin
      total++; if (ifc.code_valid !== 1'b1 || ifc.code !== 16'h0937)
        begin bad++; $display("FAIL hold_c%0d: valid=%b code=%h want 1/0937", i, ifc.code_valid, ifc.code); end
      tick(1);
    end
    press_end();
    press_start(4'd5);
    total++; if (ifc.code_valid !== 1'b1 || ifc.code !== 16'h0937 || cnt !== 3'd4 || bad_digit !== 1'b0)
      begin bad++; $display("FAIL hold_ignore: valid=%b code=%h cnt=%0d bad_digit=%b want 1/0937/4/0", ifc.code_valid, ifc.code, cnt, bad_digit); end
    ifc.code_ready = 1'b1;
    tick(1);
    total++; if (ifc.code_valid !== 1'b0 || ifc.code !== 16'h0 || cnt !== 3'd0)
      begin bad++; $display("FAIL hold_accept: valid=%b code=%h cnt=%0d want 0/0000/0", ifc.code_valid, ifc.code, cnt); end
    ifc.code_ready = 1'b0;
    press_end();
    $display("code 0937 held then transferred");
  endtask

  task automatic test_clear_offer();
    for (int k = 0; k < 4; k++) begin
      press_start(4'(k + 1));
      if (k < 3) press_end();
    end
    tick(1);
    total++; if (ifc.code_valid !== 1'b1)
      begin bad++; $display("FAIL clr_offer: valid=%b want 1", ifc.code_valid); end
    clr = 1'b1; ifc.code_ready = 1'b1;
    tick(1);
    total++; if (ifc.code_valid !== 1'b0 || ifc.code !== 16'h0 || cnt !== 3'd0)
      begin bad++; $display("FAIL clr_drop: valid=%b code=%h cnt=%0d want 0/0000/0", ifc.code_valid, ifc.code, cnt); end
    clr = 1'b0; ifc.code_ready = 1'b0;
    press_end();
    $display("clear during offer");
  endtask

  task automatic test_reset_mid();
    press_start(4'd6); press_end();
    digit_sw = 4'd2; enter = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    total++; if (cnt !== 3'd0 || ifc.code !== 16'h0 || ifc.code_valid !== 1'b0 || bad_digit !== 1'b0 || dup_error !== 1'b0)
      begin bad++; $display("FAIL rst_async: cnt=%0d code=%h valid=%b bd=%b dup=%b want all 0", cnt, ifc.code, ifc.code_valid, bad_digit, dup_error); end
    enter = 1'b0;
    @(negedge clk); rst_n = 1'b1; tick(1);
    press_start(4'd8);
    total++; if (cnt !== 3'd1 || ifc.code !== 16'h0008)
      begin bad++; $display("FAIL rst_after: cnt=%0d code=%h want 1/0008", cnt, ifc.code); end
    press_end();
    clr = 1'b1; tick(1); clr = 1'b0;
    $display("reset mid-collection");
  endtask

  task automatic test_random();
    logic [3:0] d;
    int wait_n;
    mq.delete();
    for (int it = 0; it < 24; it++) begin
      d = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      press_start(d);
      if (d > 4'd9) begin
        total++; if (bad_digit !== 1'b1 || cnt !== 3'(mq.size()) || ifc.code !== mcode())
          begin bad++; $display("FAIL rnd_bad%0d: bd=%b cnt=%0d code=%h want 1/%0d/%h", it, bad_digit, cnt, ifc.code, mq.size(), mcode()); end
        $display("press %0d digit %h rejected", it, d);
      end else begin
        mq.push_back(int'(d));
        total++; if (bad_digit !== 1'b0 || cnt !== 3'(mq.size()) || ifc.code !== mcode() || dup_error !== 1'b0)
          begin bad++; $display("FAIL rnd_dig%0d: bd=%b cnt=%0d code=%h dup=%b want 0/%0d/%h/0", it, bad_digit, cnt, ifc.code, dup_error, mq.size(), mcode()); end
        if (mq.size() == 4) begin
          tick(1);
          if (mhasdup()) begin
            total++; if (dup_error !== 1'b1 || cnt !== 3'd0 || ifc.code_valid !== 1'b0)
              begin bad++; $display("FAIL rnd_dup%0d: dup=%b cnt=%0d valid=%b want 1/0/0", it, dup_error, cnt, ifc.code_valid); end
            $display("press %0d code %h rejected (repeat)", it, mcode());
          end else begin
            wait_n = $urandom_range(0, 4);
            for (int w = 0; w <= wait_n; w++) begin
              total++; if (ifc.code_valid !== 1'b1 || ifc.code !== mcode())
                begin bad++; $display("FAIL rnd_offer%0d: valid=%b code=%h want 1/%h", it, ifc.code_valid, ifc.code, mcode()); end
              if (w == wait_n) ifc.code_ready = 1'b1;
              tick(1);
            end
            total++; if (ifc.code_valid !== 1'b0 || cnt !== 3'd0 || ifc.code !== 16'h0)
              begin bad++; $display("FAIL rnd_acc%0d: valid=%b cnt=%0d code=%h want 0/0/0000", it, ifc.code_valid, cnt, ifc.code); end
            ifc.code_ready = 1'b0;
            $display("press %0d code %h transferred after %0d waits", it, mcode(), wait_n);
          end
          mq.delete();
        end else begin
          $display("press %0d digit %h accepted", it, d);
        end
      end
      press_end();
    end
  endtask

  initial begin
    ifc.code_ready = 1'b0;
    tick(2);
    test_reset();
    test_basic();
    test_bounce();
    test_dup();
    test_bad_digit();
    test_offer_hold();
    test_clear_offer();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
